// File: rtl/apb_fabric_pkg.sv
// Shared types and helpers for the APB fabric.
// Contents: FSM state enum, one-hot decode helpers, default bus widths.
package apb_fabric_pkg;

    localparam int unsigned MAX_SLV    = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned STRB_W     = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DECERR = 2'd2
    } state_e;

    // True when exactly one bit of the slave field is set.
    function automatic logic onehot_valid(input logic [MAX_SLV-1:0] f);
        return (f != '0) && ((f & (f - MAX_SLV'(1))) == '0);
    endfunction

    // Index of the set bit; only meaningful when onehot_valid(f).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_SLV-1:0] f);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_SLV); i++) begin
            if (f[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_fabric_if.sv
// APB bus bundle between one master and NUM_SLV slaves.
// Modport slave : the fabric's view of the master side (it is the master's slave).
// Modport master: the fabric's view of the slave side (it is the slaves' master).
interface apb_fabric_if #(
    parameter int unsigned NUM_SLV = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    // Master side
    logic                      PSEL_M;
    logic                      PENABLE_M;
    logic                      PWRITE_M;
    logic [ADDR_W-1:0]         PADDR_M;
    logic [DATA_W-1:0]         PWDATA_M;
    logic [STRB_W-1:0]         PSTRB_M;
    logic [DATA_W-1:0]         PRDATA_M;
    logic                      PREADY_M;
    logic                      PSLVERR_M;

    // Slave side
    logic [NUM_SLV-1:0]        PSEL_S;
    logic                      PENABLE_S;
    logic                      PWRITE_S;
    logic [ADDR_W-1:0]         PADDR_S;
    logic [DATA_W-1:0]         PWDATA_S;
    logic [STRB_W-1:0]         PSTRB_S;
    logic [NUM_SLV*DATA_W-1:0] PRDATA_S;
    logic [NUM_SLV-1:0]        PREADY_S;
    logic [NUM_SLV-1:0]        PSLVERR_S;

    modport slave (
        input  PSEL_M, PENABLE_M, PWRITE_M, PADDR_M, PWDATA_M, PSTRB_M,
        output PRDATA_M, PREADY_M, PSLVERR_M
    );

    modport master (
        output PSEL_S, PENABLE_S, PWRITE_S, PADDR_S, PWDATA_S, PSTRB_S,
        input  PRDATA_S, PREADY_S, PSLVERR_S
    );
endinterface

// File: rtl/apb_fabric_tmo.sv
// PREADY timeout counter for one ACCESS phase.
// Ports: clk, rst (sync, active-high), clr (start of transfer), inc (wait cycle),
//        expire_c (count has reached TIMEOUT_CYC-1).
module apb_fabric_tmo #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire_c
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = '0;
        else if (inc) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_fabric.sv
// APB interconnect: one master to NUM_SLV slaves with one-hot address decode,
// decode-error default slave and per-transfer PREADY timeout.
// Ports: PCLK, PRESET (sync, active-high); m_bus (master side), s_bus (slave side);
//        TMO_CNT / DECERR_CNT only when APB_FABRIC_STATS_EN is defined.
// Response path is combinational from the latched select index so no cycle is added.
module apb_fabric
    import apb_fabric_pkg::*;
#(
    parameter int unsigned NUM_SLV     = 16,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SEL_LSB     = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        PCLK,
    input  logic        PRESET,
    apb_fabric_if.slave  m_bus,
    apb_fabric_if.master s_bus
`ifdef APB_FABRIC_STATS_EN
    ,
    output logic [15:0] TMO_CNT,
    output logic [15:0] DECERR_CNT
`endif
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [MAX_SLV-1:0]  field_c;
    logic [MAX_SLV-1:0]  pready_pad_c;
    logic [MAX_SLV-1:0]  pslverr_pad_c;
    logic [DATA_W-1:0]   prdata_arr_c [MAX_SLV];

    logic [NUM_SLV-1:0]  psel_c;
    logic                pready_c;
    logic                pslverr_c;
    logic [DATA_W-1:0]   prdata_c;
    logic                tmo_clr_c;
    logic                tmo_inc_c;
    logic                tmo_expire_c;
    logic                tmo_hit_c;
    logic                dec_hit_c;

    // Broadcast master fields to all slaves.
    assign s_bus.PENABLE_S = m_bus.PENABLE_M;
    assign s_bus.PWRITE_S  = m_bus.PWRITE_M;
    assign s_bus.PADDR_S   = m_bus.PADDR_M;
    assign s_bus.PWDATA_S  = m_bus.PWDATA_M;
    assign s_bus.PSTRB_S   = m_bus.PSTRB_M;

    // Pad per-slave vectors to MAX_SLV so the 4-bit index is always in range.
    assign field_c       = MAX_SLV'(m_bus.PADDR_M[SEL_LSB +: NUM_SLV]);
    assign pready_pad_c  = MAX_SLV'(s_bus.PREADY_S);
    assign pslverr_pad_c = MAX_SLV'(s_bus.PSLVERR_S);

    for (genvar g = 0; g < int'(MAX_SLV); g++) begin : g_rd
        if (g < int'(NUM_SLV)) begin : g_used
            assign prdata_arr_c[g] = s_bus.PRDATA_S[g*DATA_W +: DATA_W];
        end else begin : g_pad
            assign prdata_arr_c[g] = '0;
        end
    end

    apb_fabric_tmo #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk      (PCLK),
        .rst      (PRESET),
        .clr      (tmo_clr_c),
        .inc      (tmo_inc_c),
        .expire_c (tmo_expire_c)
    );

    // Decode, next state and response mux.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        psel_c    = '0;
        pready_c  = 1'b0;
        pslverr_c = 1'b0;
        prdata_c  = '0;
        tmo_clr_c = 1'b0;
        tmo_inc_c = 1'b0;
        tmo_hit_c = 1'b0;
        dec_hit_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m_bus.PSEL_M && !m_bus.PENABLE_M) begin
                    if (onehot_valid(field_c)) begin
                        psel_c    = NUM_SLV'(field_c);
                        idx_d     = onehot_to_idx(field_c);
                        tmo_clr_c = 1'b1;
                        state_d   = ACCESS;
                    end else begin
                        state_d   = DECERR;
                    end
                end else if (m_bus.PENABLE_M) begin
                    // ACCESS phase with no preceding SETUP: answer as a decode error now.
                    pready_c  = 1'b1;
                    pslverr_c = 1'b1;
                    dec_hit_c = 1'b1;
                end
            end

            ACCESS: begin
                if (!m_bus.PSEL_M) begin
                    // Master abandoned the transfer: no response, counter untouched.
                    state_d = IDLE;
                end else begin
                    psel_c = NUM_SLV'(MAX_SLV'(1) << idx_q);
                    if (pready_pad_c[idx_q]) begin
                        pready_c  = 1'b1;
                        pslverr_c = pslverr_pad_c[idx_q];
                        prdata_c  = prdata_arr_c[idx_q];
                        state_d   = IDLE;
                    end else if (tmo_expire_c) begin
                        pready_c  = 1'b1;
                        pslverr_c = 1'b1;
                        tmo_hit_c = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        tmo_inc_c = 1'b1;
                    end
                end
            end

            DECERR: begin
                pready_c  = 1'b1;
                pslverr_c = 1'b1;
                dec_hit_c = 1'b1;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign s_bus.PSEL_S    = psel_c;
    assign m_bus.PREADY_M  = pready_c;
    assign m_bus.PSLVERR_M = pslverr_c;
    assign m_bus.PRDATA_M  = prdata_c;

`ifdef APB_FABRIC_STATS_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] decerr_cnt_q, decerr_cnt_d;

    // Saturating event counters.
    always_comb begin
        tmo_cnt_d    = tmo_cnt_q;
        decerr_cnt_d = decerr_cnt_q;
        if (tmo_hit_c && (tmo_cnt_q != 16'hFFFF))    tmo_cnt_d    = tmo_cnt_q + 16'd1;
        if (dec_hit_c && (decerr_cnt_q != 16'hFFFF)) decerr_cnt_d = decerr_cnt_q + 16'd1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tmo_cnt_q    <= '0;
            decerr_cnt_q <= '0;
        end else begin
            tmo_cnt_q    <= tmo_cnt_d;
            decerr_cnt_q <= decerr_cnt_d;
        end
    end

    assign TMO_CNT    = tmo_cnt_q;
    assign DECERR_CNT = decerr_cnt_q;
`else
    logic unused_stats_c;
    assign unused_stats_c = tmo_hit_c ^ dec_hit_c;
`endif

endmodule

// File: tb/tb_apb_fabric.sv
// Directed bench for apb_fabric: inputs driven 1 ns after the rising edge,
// outputs sampled on the falling edge.
module tb_apb_fabric;

    localparam int unsigned NUM_SLV = 16;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;

    logic clk = 1'b0;
    logic rst;

    int n_vec = 0;
    int n_err = 0;

    apb_fabric_if #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef APB_FABRIC_STATS_EN
    logic [15:0] tmo_cnt;
    logic [15:0] decerr_cnt;
`endif

    apb_fabric #(
        .NUM_SLV     (NUM_SLV),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SEL_LSB     (16),
        .TIMEOUT_CYC (64)
    ) u_dut (
        .PCLK   (clk),
        .PRESET (rst),
        .m_bus  (bus),
        .s_bus  (bus)
`ifdef APB_FABRIC_STATS_EN
        ,
        .TMO_CNT    (tmo_cnt),
        .DECERR_CNT (decerr_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_rd(input int i, input logic [31:0] v);
        bus.PRDATA_S[i*32 +: 32] = v;
    endtask

    task automatic master(input logic sel, input logic en, input logic wr, input logic [31:0] addr);
        bus.PSEL_M    = sel;
        bus.PENABLE_M = en;
        bus.PWRITE_M  = wr;
        bus.PADDR_M   = addr;
    endtask

    task automatic chk_rsp(input string tag, input logic rdy, input logic err, input logic [31:0] d);
        check_val({tag, "_pready"},  64'(bus.PREADY_M),  64'(rdy));
        check_val({tag, "_pslverr"}, 64'(bus.PSLVERR_M), 64'(err));
        check_val({tag, "_prdata"},  64'(bus.PRDATA_M),  64'(d));
    endtask

    initial begin
        rst = 1'b1;
        master(1'b0, 1'b0, 1'b0, 32'h0);
        bus.PWDATA_M  = 32'h0;
        bus.PSTRB_M   = 4'h0;
        bus.PREADY_S  = '0;
        bus.PSLVERR_S = '0;
        for (int i = 0; i < 16; i++) set_rd(i, {16'hD0D0, 16'(i)});

        // Reset state
        cyc(); cyc(); smp();
        check_val("rst_psel_s", 64'(bus.PSEL_S), 64'h0);
        chk_rsp("rst", 1'b0, 1'b0, 32'h0);

        // Write to slave1, ready after two wait states
        cyc();
        rst = 1'b0;
        master(1'b1, 1'b0, 1'b1, 32'h0002_0010);
        bus.PWDATA_M = 32'h1234_5678;
        bus.PSTRB_M  = 4'hF;
        smp();
        check_val("wr_setup_psel", 64'(bus.PSEL_S), 64'h0002);
        check_val("wr_paddr_s",    64'(bus.PADDR_S), 64'h0002_0010);
        check_val("wr_pwdata_s",   64'(bus.PWDATA_S), 64'h1234_5678);
        check_val("wr_pwrite_s",   64'(bus.PWRITE_S), 64'h1);
        check_val("wr_pstrb_s",    64'(bus.PSTRB_S), 64'hF);
        check_val("wr_setup_rdy",  64'(bus.PREADY_M), 64'h0);
        cyc(); bus.PENABLE_M = 1'b1; smp();
        check_val("wr_acc1_psel", 64'(bus.PSEL_S), 64'h0002);
        chk_rsp("wr_acc1", 1'b0, 1'b0, 32'h0);
        cyc(); smp();
        check_val("wr_acc2_psel", 64'(bus.PSEL_S), 64'h0002);
        chk_rsp("wr_acc2", 1'b0, 1'b0, 32'h0);
        cyc(); bus.PREADY_S = 16'h0002; smp();
        check_val("wr_acc3_psel", 64'(bus.PSEL_S), 64'h0002);
        chk_rsp("wr_acc3", 1'b1, 1'b0, 32'hD0D0_0001);
        cyc(); master(1'b0, 1'b0, 1'b0, 32'h0); bus.PREADY_S = '0; smp();
        check_val("wr_done_psel", 64'(bus.PSEL_S), 64'h0);
        check_val("wr_done_rdy",  64'(bus.PREADY_M), 64'h0);

        // Zero-wait read from slave0, then back-to-back erroring read from slave4
        cyc();
        master(1'b1, 1'b0, 1'b0, 32'h0001_0004);
        set_rd(0, 32'hDEAD_BEEF);
        bus.PREADY_S = 16'h0001;
        smp();
        check_val("rd0_setup_psel", 64'(bus.PSEL_S), 64'h0001);
        check_val("rd0_setup_rdy",  64'(bus.PREADY_M), 64'h0);
        cyc(); bus.PENABLE_M = 1'b1; smp();
        chk_rsp("rd0_acc", 1'b1, 1'b0, 32'hDEAD_BEEF);
        cyc();
        master(1'b1, 1'b0, 1'b0, 32'h0010_0000);
        set_rd(4, 32'hCAFE_0004);
        bus.PREADY_S  = 16'h0010;
        bus.PSLVERR_S = 16'h0010;
        smp();
        check_val("rd4_setup_psel", 64'(bus.PSEL_S), 64'h0010);
        cyc(); bus.PENABLE_M = 1'b1; smp();
        chk_rsp("rd4_acc", 1'b1, 1'b1, 32'hCAFE_0004);
        cyc(); master(1'b0, 1'b0, 1'b0, 32'h0); bus.PSLVERR_S = '0; smp();

        // Decode errors: multi-hot field, then empty field
        bus.PREADY_S = 16'hFFFF;
        cyc(); master(1'b1, 1'b0, 1'b0, 32'h0003_0000); smp();
        check_val("dec_mh_setup_psel", 64'(bus.PSEL_S), 64'h0);
        cyc(); bus.PENABLE_M = 1'b1; smp();
        check_val("dec_mh_acc_psel", 64'(bus.PSEL_S), 64'h0);
        chk_rsp("dec_mh", 1'b1, 1'b1, 32'h0);
        cyc(); master(1'b1, 1'b0, 1'b0, 32'h0000_0000); smp();
        check_val("dec_z_setup_psel", 64'(bus.PSEL_S), 64'h0);
        cyc(); bus.PENABLE_M = 1'b1; smp();
        check_val("dec_z_acc_psel", 64'(bus.PSEL_S), 64'h0);
        chk_rsp("dec_z", 1'b1, 1'b1, 32'h0);
        cyc(); master(1'b0, 1'b0, 1'b0, 32'h0); bus.PREADY_S = '0; smp();
`ifdef APB_FABRIC_STATS_EN
        check_val("decerr_cnt_2", 64'(decerr_cnt), 64'd2);
`endif

        // Slave2 never ready: timeout on ACCESS cycle 64
        cyc(); master(1'b1, 1'b0, 1'b0, 32'h0004_0000); set_rd(2, 32'h2222_2222); smp();
        check_val("tmo_setup_psel", 64'(bus.PSEL_S), 64'h0004);
        for (int k = 1; k <= 64; k++) begin
            cyc();
            bus.PENABLE_M = 1'b1;
            smp();
            if (k < 64) begin
                check_val("tmo_wait_rdy", 64'(bus.PREADY_M), 64'h0);
            end else begin
                check_val("tmo_hit_psel", 64'(bus.PSEL_S), 64'h0004);
                chk_rsp("tmo_hit", 1'b1, 1'b1, 32'h0);
            end
        end
        // Next SETUP immediately accepted
        cyc();
        master(1'b1, 1'b0, 1'b0, 32'h0001_0000);
        set_rd(0, 32'hA5A5_0000);
        bus.PREADY_S = 16'h0001;
        smp();
        check_val("post_tmo_psel", 64'(bus.PSEL_S), 64'h0001);
        cyc(); bus.PENABLE_M = 1'b1; smp();
        chk_rsp("post_tmo", 1'b1, 1'b0, 32'hA5A5_0000);
        cyc(); master(1'b0, 1'b0, 1'b0, 32'h0); bus.PREADY_S = '0; smp();
`ifdef APB_FABRIC_STATS_EN
        check_val("tmo_cnt_1", 64'(tmo_cnt), 64'd1);
`endif

        // Slave ready in the would-be timeout cycle wins
        cyc(); master(1'b1, 1'b0, 1'b0, 32'h0004_0000); smp();
        for (int k = 1; k <= 64; k++) begin
            cyc();
            bus.PENABLE_M = 1'b1;
            if (k == 64) bus.PREADY_S = 16'h0004;
            smp();
        end
        chk_rsp("tmo_race", 1'b1, 1'b0, 32'h2222_2222);
        cyc(); master(1'b0, 1'b0, 1'b0, 32'h0); bus.PREADY_S = '0; smp();
`ifdef APB_FABRIC_STATS_EN
        check_val("tmo_cnt_still_1", 64'(tmo_cnt), 64'd1);
`endif

        // Master drops PSEL mid-wait: abort with no response
        cyc(); master(1'b1, 1'b0, 1'b0, 32'h0008_0000); smp();
        cyc(); bus.PENABLE_M = 1'b1; smp();
        check_val("abort_wait_psel", 64'(bus.PSEL_S), 64'h0008);
        cyc(); bus.PSEL_M = 1'b0; smp();
        check_val("abort_psel", 64'(bus.PSEL_S), 64'h0);
        chk_rsp("abort", 1'b0, 1'b0, 32'h0);

        // ACCESS with no SETUP answered as decode error in the same cycle
        cyc(); master(1'b1, 1'b1, 1'b0, 32'h0001_0000); bus.PREADY_S = 16'h0001; smp();
        check_val("proto_psel", 64'(bus.PSEL_S), 64'h0);
        chk_rsp("proto", 1'b1, 1'b1, 32'h0);
        cyc(); master(1'b0, 1'b0, 1'b0, 32'h0); bus.PREADY_S = '0; smp();
`ifdef APB_FABRIC_STATS_EN
        check_val("decerr_cnt_3", 64'(decerr_cnt), 64'd3);
`endif

        // Reset during a slave3 wait
        cyc(); master(1'b1, 1'b0, 1'b0, 32'h0008_0000); smp();
        cyc(); bus.PENABLE_M = 1'b1; smp();
        check_val("rstmid_wait_psel", 64'(bus.PSEL_S), 64'h0008);
        cyc(); rst = 1'b1; smp();
        cyc(); rst = 1'b0; master(1'b0, 1'b0, 1'b0, 32'h0); smp();
        check_val("rstmid_psel", 64'(bus.PSEL_S), 64'h0);
        chk_rsp("rstmid", 1'b0, 1'b0, 32'h0);
`ifdef APB_FABRIC_STATS_EN
        check_val("rstmid_tmo_cnt",    64'(tmo_cnt), 64'd0);
        check_val("rstmid_decerr_cnt", 64'(decerr_cnt), 64'd0);
`endif
        cyc();
        master(1'b1, 1'b0, 1'b1, 32'h0001_0000);
        bus.PREADY_S = 16'h0001;
        smp();
        check_val("post_rst_psel", 64'(bus.PSEL_S), 64'h0001);
        cyc(); bus.PENABLE_M = 1'b1; smp();
        chk_rsp("post_rst", 1'b1, 1'b0, 32'hA5A5_0000);
        cyc(); master(1'b0, 1'b0, 1'b0, 32'h0); bus.PREADY_S = '0; smp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
